qinfen_apb3_timer_regs: RTL and testbench
=========================================

# qinfen_apb3_timer_regs

Register bank and 32-bit down-counter timer that sits directly downstream of the APB3 slave interface. It consumes that interface's register-side strobes (addr, read_en, write_en, byte_strobe, wdata) and returns rdata. It exposes a maskable interrupt to the system. The APB side is zero-wait-state, so read data must be stable in the APB access cycle.

## Interface
Parameters:
- ADDRWIDTH, 12, register address width; must match the upstream APB3 slave interface.
- ID_VALUE, 32'h5154_0001, constant returned by the ID register.

Ports:
- pclk  input  1  clock; all logic is single-clock.
- presetn  input  1  reset; synchronous, active-low, sampled on the rising edge of pclk.
- addr  input  ADDRWIDTH  byte address; bits [1:0] are ignored.
- read_en  input  1  high for the whole APB read transfer (setup and access cycles).
- write_en  input  1  high only in the APB write setup cycle.
- byte_strobe  input  4  per-byte write enables.
- wdata  input  32  write data.
- rdata  output  32  registered read data.
- timer_int  output  1  registered level interrupt, equal to INTSTAT[0] & CTRL[1].

## Operation
Register map (word offsets):
- 0x000 CTRL, RW, bits [2:0]:
  - bit 0 EN
  - bit 1 INTEN
  - bit 2 ONESHOT
  - other bits read as 0.
- 0x004 RELOAD, RW, 32 bits.
- 0x008 VALUE, RW, 32 bits; the live counter.
- 0x00C INTSTAT, bit 0, write-1-to-clear; writing 0 has no effect.
- 0x010 ID, RO; always returns ID_VALUE.
- 0x014 PRESCALE, RW, bits [7:0]; present only with the macro (see Configuration).
- Unmapped offsets read 0; writes to them are ignored.

Writes:
- Applied on the clock edge that ends the write_en cycle.
- Each byte lane is written only if its byte_strobe bit is set.
- For INTSTAT, only byte 0 is significant.

Reads:
- On every edge with read_en=1, rdata loads the mux output for addr.
- With read_en=0, rdata holds its value.
- Reads have no side effects.

Counter behaviour while EN=1, on each tick (a tick is every cycle when the prescaler is absent):
- VALUE != 0: VALUE decrements by 1.
- VALUE == 0 and ONESHOT=0: VALUE loads RELOAD and INTSTAT[0] is set.
- VALUE == 0 and ONESHOT=1: INTSTAT[0] is set, CTRL.EN is cleared, and VALUE stays 0.
- While EN=0, VALUE holds.

Boundary conditions:
- Software write to VALUE on the same cycle as a tick: the software write wins and no decrement occurs.
- Software write to CTRL on the same cycle as a one-shot expiry: the software value wins.
- Hardware set of INTSTAT on the same cycle as a W1C: the set wins, so INTSTAT[0] stays 1.
- RELOAD=0 in periodic mode: interrupt set every tick.
- A partial-byte write to VALUE merges with the current (pre-decrement) value.

## Timing
- Reset (presetn=0 at an edge): rdata, CTRL, RELOAD, VALUE, INTSTAT, PRESCALE and the prescale counter all become 0, and timer_int becomes 0.
- Write latency: 1 cycle. The register shows the new value in the cycle after write_en.
- Read latency: 1 cycle. Data is sampled in the setup cycle and valid for the whole access cycle.
- timer_int is registered. It rises 1 cycle after INTSTAT[0] sets with INTEN=1.
- Periodic period is (RELOAD+1) ticks.
- Reset asserted mid-count aborts immediately; there is no pending interrupt afterwards.

## Configuration
- Macro: QINFEN_TIMER_PRESCALER_EN.
- Defined:
  - PRESCALE register and an 8-bit prescale counter are present.
  - A tick occurs every (PRESCALE+1) pclk cycles while EN=1.
  - The prescale counter clears while EN=0 and on any write to PRESCALE.
- Undefined:
  - No prescaler logic; a tick occurs every cycle.
  - Offset 0x014 is unmapped (reads 0, writes ignored).

## Structure
- Shared package/header qinfen_timer_pkg holds:
  - register offsets: CTRL_OFS, RELOAD_OFS, VALUE_OFS, INTSTAT_OFS, ID_OFS, PRESCALE_OFS
  - CTRL bit positions: EN_BIT, INTEN_BIT, ONESHOT_BIT
  - PRESCALE_W=8
- Sub-module qinfen_timer_counter contains VALUE, the reload/one-shot logic, the prescaler and the expiry pulse.
- The top level keeps address decode, byte-strobe merge, the read mux and INTSTAT.

## Test plan
- Reset: assert presetn=0 for 2 cycles, then read every register. Expect all 0, ID=32'h5154_0001, timer_int=0.
- Byte strobes: write RELOAD=32'hAABB_CCDD with byte_strobe=4'b0101 over a reset value of 0. RELOAD must read 32'h00BB_00DD.
- Periodic mode: RELOAD=3, VALUE=3, CTRL=3'b011.
  - VALUE must go 3,2,1,0,3,2…
  - INTSTAT[0] sets on the 4th tick; timer_int rises 1 cycle later.
  - W1C to INTSTAT then drops timer_int on the next cycle.
- One-shot mode: VALUE=2, CTRL=3'b101.
  - After 3 ticks: INTSTAT[0]=1, CTRL reads 3'b100, VALUE holds 0.
  - timer_int stays 0 because INTEN=0.
- Collisions:
  - W1C to INTSTAT issued in the same cycle as an expiry: INTSTAT[0] remains 1.
  - Write VALUE=100 during counting: VALUE reads 100, then 99.
- Prescaler, with the macro defined: PRESCALE=3, VALUE=2, EN=1. Expiry occurs 12 pclk cycles after enable.

Source files
------------

// File: rtl/qinfen_timer_pkg.sv
// Shared offsets, CTRL bit positions and the byte-lane merge helper for the
// qinfen timer register bank.
package qinfen_timer_pkg;

    localparam int unsigned CTRL_OFS     = 32'h000;
    localparam int unsigned RELOAD_OFS   = 32'h004;
    localparam int unsigned VALUE_OFS    = 32'h008;
    localparam int unsigned INTSTAT_OFS  = 32'h00C;
    localparam int unsigned ID_OFS       = 32'h010;
    localparam int unsigned PRESCALE_OFS = 32'h014;

    localparam int EN_BIT      = 0;
    localparam int INTEN_BIT   = 1;
    localparam int ONESHOT_BIT = 2;

    localparam int PRESCALE_W = 8;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wr,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = wr[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/qinfen_apb3_timer_regs_if.sv
// Register-side strobes coming out of the APB3 slave front end.
interface qinfen_apb3_timer_regs_if #(
    parameter int ADDRWIDTH = 12
) ();
    logic [ADDRWIDTH-1:0] addr;
    logic                 read_en;
    logic                 write_en;
    logic [3:0]           byte_strobe;
    logic [31:0]          wdata;
    logic [31:0]          rdata;

    modport master (output addr, read_en, write_en, byte_strobe, wdata, input rdata);
    modport slave  (input addr, read_en, write_en, byte_strobe, wdata, output rdata);
endinterface

// File: rtl/qinfen_timer_counter.sv
// 32-bit down-counter with reload/one-shot handling and the expiry pulse.
// Optional prescaler: QINFEN_TIMER_PRESCALER_EN.
module qinfen_timer_counter
    import qinfen_timer_pkg::*;
(
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  en,
    input  logic                  oneshot,
    input  logic                  value_we,
    input  logic [31:0]           value_wdata,
    input  logic [31:0]           reload,
`ifdef QINFEN_TIMER_PRESCALER_EN
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  prescale_we,
`endif
    output logic [31:0]           value,
    output logic                  expire
);

    logic [31:0] value_q, value_d;
    logic        tick;

`ifdef QINFEN_TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

    // Tick once every (prescale+1) enabled cycles; counter restarts when disabled or reprogrammed.
    always_comb begin
        tick      = en && (pre_cnt_q == prescale);
        pre_cnt_d = pre_cnt_q + 1'b1;
        if (!en || prescale_we || tick) pre_cnt_d = '0;
    end

    // Prescale counter register.
    always_ff @(posedge pclk) begin
        if (!presetn) pre_cnt_q <= '0;
        else          pre_cnt_q <= pre_cnt_d;
    end
`else
    assign tick = en;
`endif

    // A software write consumes the tick: no decrement and no expiry that cycle.
    always_comb begin
        value_d = value_q;
        expire  = 1'b0;
        if (value_we) begin
            value_d = value_wdata;
        end else if (tick) begin
            if (value_q != 32'd0) begin
                value_d = value_q - 32'd1;
            end else begin
                expire = 1'b1;
                if (!oneshot) value_d = reload;
            end
        end
    end

    // Counter register.
    always_ff @(posedge pclk) begin
        if (!presetn) value_q <= '0;
        else          value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/qinfen_apb3_timer_regs.sv
// Timer register bank: address decode, byte-strobe merge, read mux, INTSTAT
// and the registered interrupt. Optional PRESCALE register: QINFEN_TIMER_PRESCALER_EN.
module qinfen_apb3_timer_regs
    import qinfen_timer_pkg::*;
#(
    parameter int          ADDRWIDTH = 12,
    parameter logic [31:0] ID_VALUE  = 32'h5154_0001
) (
    input  logic                     pclk,
    input  logic                     presetn,
    qinfen_apb3_timer_regs_if.slave  bus,
    output logic                     timer_int
);

    logic [ADDRWIDTH-1:0] addr_aligned;
    logic sel_ctrl, sel_reload, sel_value, sel_intstat, sel_id;

    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] reload_q, reload_d;
    logic        intstat_q, intstat_d;
    logic        timer_int_q, timer_int_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_mux;

    logic        ctrl_we, value_we, w1c;
    logic [31:0] value_q, value_wdata;
    logic        expire;

    assign addr_aligned = bus.addr & ~ADDRWIDTH'(3);
    assign sel_ctrl     = (addr_aligned == ADDRWIDTH'(CTRL_OFS));
    assign sel_reload   = (addr_aligned == ADDRWIDTH'(RELOAD_OFS));
    assign sel_value    = (addr_aligned == ADDRWIDTH'(VALUE_OFS));
    assign sel_intstat  = (addr_aligned == ADDRWIDTH'(INTSTAT_OFS));
    assign sel_id       = (addr_aligned == ADDRWIDTH'(ID_OFS));

    assign ctrl_we     = bus.write_en && sel_ctrl && bus.byte_strobe[0];
    assign value_we    = bus.write_en && sel_value && (|bus.byte_strobe);
    assign value_wdata = merge_bytes(value_q, bus.wdata, bus.byte_strobe);
    assign w1c         = bus.write_en && sel_intstat && bus.byte_strobe[0] && bus.wdata[0];

`ifdef QINFEN_TIMER_PRESCALER_EN
    logic                  sel_prescale;
    logic                  prescale_we;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;

    assign sel_prescale = (addr_aligned == ADDRWIDTH'(PRESCALE_OFS));
    assign prescale_we  = bus.write_en && sel_prescale;

    // PRESCALE lives in byte 0 only.
    always_comb begin
        prescale_d = prescale_q;
        if (prescale_we && bus.byte_strobe[0]) prescale_d = bus.wdata[PRESCALE_W-1:0];
    end

    // PRESCALE register.
    always_ff @(posedge pclk) begin
        if (!presetn) prescale_q <= '0;
        else          prescale_q <= prescale_d;
    end
`endif

    qinfen_timer_counter u_counter (
        .pclk        (pclk),
        .presetn     (presetn),
        .en          (ctrl_q[EN_BIT]),
        .oneshot     (ctrl_q[ONESHOT_BIT]),
        .value_we    (value_we),
        .value_wdata (value_wdata),
        .reload      (reload_q),
`ifdef QINFEN_TIMER_PRESCALER_EN
        .prescale    (prescale_q),
        .prescale_we (prescale_we),
`endif
        .value       (value_q),
        .expire      (expire)
    );

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rd_mux = '0;
        if      (sel_ctrl)    rd_mux = {29'b0, ctrl_q};
        else if (sel_reload)  rd_mux = reload_q;
        else if (sel_value)   rd_mux = value_q;
        else if (sel_intstat) rd_mux = {31'b0, intstat_q};
        else if (sel_id)      rd_mux = ID_VALUE;
`ifdef QINFEN_TIMER_PRESCALER_EN
        else if (sel_prescale) rd_mux = 32'(prescale_q);
`endif
    end

    // Next-state for CTRL, RELOAD, INTSTAT, interrupt and read data.
    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_we) begin
            ctrl_d = bus.wdata[2:0];
        end else if (expire && ctrl_q[ONESHOT_BIT]) begin
            ctrl_d[EN_BIT] = 1'b0;
        end

        reload_d = reload_q;
        if (bus.write_en && sel_reload) reload_d = merge_bytes(reload_q, bus.wdata, bus.byte_strobe);

        // Hardware set beats a simultaneous W1C.
        intstat_d   = expire | (intstat_q & ~w1c);
        timer_int_d = intstat_q & ctrl_q[INTEN_BIT];

        rdata_d = rdata_q;
        if (bus.read_en) rdata_d = rd_mux;
    end

    // Register bank state.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            ctrl_q      <= '0;
            reload_q    <= '0;
            intstat_q   <= 1'b0;
            timer_int_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            reload_q    <= reload_d;
            intstat_q   <= intstat_d;
            timer_int_q <= timer_int_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign timer_int = timer_int_q;

endmodule

// File: tb/tb_qinfen_apb3_timer_regs.sv
// Directed bench for qinfen_apb3_timer_regs; prescaler section active when
// QINFEN_TIMER_PRESCALER_EN is defined.
module tb_qinfen_apb3_timer_regs;
    import qinfen_timer_pkg::*;

    logic pclk = 1'b0;
    logic presetn;
    logic timer_int;

    qinfen_apb3_timer_regs_if #(.ADDRWIDTH(12)) bus ();

    qinfen_apb3_timer_regs #(
        .ADDRWIDTH (12),
        .ID_VALUE  (32'h5154_0001)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .bus       (bus),
        .timer_int (timer_int)
    );

    always #5 pclk = ~pclk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge pclk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.addr        = a;
        bus.wdata       = d;
        bus.byte_strobe = s;
        bus.write_en    = 1'b1;
        cycle();
        bus.write_en    = 1'b0;
        bus.byte_strobe = 4'b0000;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus.addr    = a;
        bus.read_en = 1'b1;
        cycle();
        bus.read_en = 1'b0;
        check(tag_q.pop_front(), bus.rdata, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] per_seq [6];
        logic [31:0] pre_exp;
        per_seq = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2};

        bus.addr = '0; bus.read_en = 1'b0; bus.write_en = 1'b0;
        bus.byte_strobe = '0; bus.wdata = '0;
        presetn = 1'b0;
        cycle();
        cycle();
        presetn = 1'b1;

        // reset state
        check("rst_timer_int", 32'(timer_int), 32'd0);
        rd(12'(CTRL_OFS),     32'd0,            "rst_ctrl");
        rd(12'(RELOAD_OFS),   32'd0,            "rst_reload");
        rd(12'(VALUE_OFS),    32'd0,            "rst_value");
        rd(12'(INTSTAT_OFS),  32'd0,            "rst_intstat");
        rd(12'(ID_OFS),       32'h5154_0001,    "rst_id");
        rd(12'(PRESCALE_OFS), 32'd0,            "rst_prescale");
        rd(12'h018,           32'd0,            "rst_unmapped");
        rd(12'h013,           32'h5154_0001,    "id_low_bits_ignored");

        // PRESCALE exists only with the macro; otherwise writes there are dropped
`ifdef QINFEN_TIMER_PRESCALER_EN
        pre_exp = 32'h0000_00FF;
`else
        pre_exp = 32'd0;
`endif
        wr(12'(PRESCALE_OFS), 32'h0000_01FF, 4'b1111);
        rd(12'(PRESCALE_OFS), pre_exp, "prescale_rw");
        wr(12'(PRESCALE_OFS), 32'd0, 4'b1111);

        // byte strobes
        wr(12'(RELOAD_OFS), 32'hAABB_CCDD, 4'b0101);
        rd(12'(RELOAD_OFS), 32'h00BB_00DD, "reload_strobe");

        // periodic mode
        wr(12'(RELOAD_OFS), 32'd3, 4'b1111);
        wr(12'(VALUE_OFS),  32'd3, 4'b1111);
        wr(12'(CTRL_OFS),   32'd3, 4'b1111);
        for (int i = 0; i < 6; i++) begin
            rd(12'(VALUE_OFS), per_seq[i], $sformatf("periodic_value_%0d", i));
            if (i == 3) check("int_before_rise", 32'(timer_int), 32'd0);
            if (i == 4) check("int_rise",        32'(timer_int), 32'd1);
        end
        wr(12'(CTRL_OFS),    32'd2, 4'b1111);
        wr(12'(INTSTAT_OFS), 32'd1, 4'b0001);
        check("int_after_w1c_edge", 32'(timer_int), 32'd1);
        cycle();
        check("int_dropped", 32'(timer_int), 32'd0);
        rd(12'(VALUE_OFS),   32'd0, "frozen_value");
        rd(12'(INTSTAT_OFS), 32'd0, "intstat_cleared");

        // one-shot mode
        wr(12'(VALUE_OFS), 32'd2, 4'b1111);
        wr(12'(CTRL_OFS),  32'd5, 4'b1111);
        cycle(); cycle(); cycle();
        rd(12'(INTSTAT_OFS), 32'd1, "oneshot_intstat");
        rd(12'(CTRL_OFS),    32'd4, "oneshot_ctrl");
        rd(12'(VALUE_OFS),   32'd0, "oneshot_value");
        check("oneshot_no_int", 32'(timer_int), 32'd0);

        // W1C colliding with expiry (RELOAD=0 expires every tick)
        wr(12'(INTSTAT_OFS), 32'd1, 4'b0001);
        rd(12'(INTSTAT_OFS), 32'd0, "w1c_clear");
        wr(12'(RELOAD_OFS),  32'd0, 4'b1111);
        wr(12'(VALUE_OFS),   32'd0, 4'b1111);
        wr(12'(CTRL_OFS),    32'd1, 4'b1111);
        wr(12'(INTSTAT_OFS), 32'd1, 4'b0001);
        rd(12'(INTSTAT_OFS), 32'd1, "w1c_vs_set");
        rd(12'(VALUE_OFS),   32'd0, "reload0_value");

        // software VALUE write during counting, then partial merge
        wr(12'(RELOAD_OFS), 32'd1000, 4'b1111);
        wr(12'(VALUE_OFS),  32'd100,  4'b1111);
        rd(12'(VALUE_OFS),  32'd100,  "sw_value_wins");
        rd(12'(VALUE_OFS),  32'd99,   "sw_value_then_dec");
        wr(12'(VALUE_OFS),  32'h0000_1200, 4'b0010);
        rd(12'(VALUE_OFS),  32'h0000_1262, "value_partial_merge");
        rd(12'(VALUE_OFS),  32'h0000_1261, "value_after_merge");

`ifdef QINFEN_TIMER_PRESCALER_EN
        wr(12'(CTRL_OFS),     32'd0, 4'b1111);
        wr(12'(INTSTAT_OFS),  32'd1, 4'b0001);
        wr(12'(PRESCALE_OFS), 32'd3, 4'b1111);
        wr(12'(VALUE_OFS),    32'd2, 4'b1111);
        wr(12'(CTRL_OFS),     32'd1, 4'b1111);
        repeat (11) cycle();
        rd(12'(INTSTAT_OFS), 32'd0, "prescale_not_yet");
        rd(12'(INTSTAT_OFS), 32'd1, "prescale_expiry_12");
        wr(12'(PRESCALE_OFS), 32'd0, 4'b1111);
`endif

        // reset in the middle of counting with an interrupt pending
        wr(12'(RELOAD_OFS), 32'd0, 4'b1111);
        wr(12'(VALUE_OFS),  32'd0, 4'b1111);
        wr(12'(CTRL_OFS),   32'd3, 4'b1111);
        cycle(); cycle();
        check("int_before_reset", 32'(timer_int), 32'd1);
        presetn = 1'b0;
        cycle();
        presetn = 1'b1;
        check("int_after_reset", 32'(timer_int), 32'd0);
        rd(12'(INTSTAT_OFS), 32'd0, "intstat_after_reset");
        rd(12'(CTRL_OFS),    32'd0, "ctrl_after_reset");
        rd(12'(VALUE_OFS),   32'd0, "value_after_reset");
        check("int_stays_low", 32'(timer_int), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
